// File: rtl/mc_sequencer.sv
// Multicycle control FSM for the 8-bit-PC MIPS datapath: PC, IR, decode, strobes, EPC.
// Optional multiply support is enabled with the CTRL_MUL_EN macro.
module mc_sequencer #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter logic [7:0] EXC_VECTOR = 8'hF0,
  parameter int         MUL_LAT    = 3
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        SYS_load,
  input  logic [7:0]  SYS_pc_val,
  input  logic [31:0] seq_instruction,
  input  logic        seq_alu_zero,
  input  logic        seq_alu_ovf,
  output logic [7:0]  seq_pc,
  output logic [31:0] seq_ir,
  output logic        seq_ir_write,
  output logic [3:0]  seq_alu_control,
  output logic        seq_alu_src_imm,
  output logic        seq_reg_dst,
  output logic        seq_reg_write,
  output logic        seq_mem_read,
  output logic        seq_mem_write,
  output logic        seq_mem_to_reg,
  output logic [7:0]  seq_epc,
  output logic        seq_epc_write,
  output logic [1:0]  seq_exc_cause,
  output logic [2:0]  seq_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_EXC    = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [31:0] r_ir;
  logic [7:0]  r_epc;
  logic [1:0]  r_exc_cause;
  logic        r_ir_write;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_epc_write;
  logic [3:0]  r_alu_control;
  logic        r_alu_src_imm;
  logic        r_reg_dst;
  logic        r_mem_to_reg;
  logic [7:0]  r_mul_cnt;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_is_r;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_is_beq;
  logic        w_is_addi;
  logic        w_is_j;
  logic        w_op_valid;
  logic [3:0]  w_r_code;
  logic        w_r_valid;
  logic        w_is_mul;
  logic        w_mul_op;
  logic        w_ovf_chk;
  logic [3:0]  w_exec_code;
  logic        w_exec_imm;
  logic        w_exec_dst;
  logic [7:0]  w_pc_plus4;
  logic [7:0]  w_br_target;

  assign w_op       = r_ir[31:26];
  assign w_funct    = r_ir[5:0];
  assign w_is_r     = (w_op == OP_R);
  assign w_is_lw    = (w_op == OP_LW);
  assign w_is_sw    = (w_op == OP_SW);
  assign w_is_beq   = (w_op == OP_BEQ);
  assign w_is_addi  = (w_op == OP_ADDI);
  assign w_is_j     = (w_op == OP_J);
  assign w_op_valid = w_is_r | w_is_lw | w_is_sw | w_is_beq | w_is_addi;

  always_comb begin
    w_r_code  = 4'd2;
    w_r_valid = 1'b1;
    w_is_mul  = 1'b0;
    case (w_funct)
      6'b100100: w_r_code = 4'd0;
      6'b100101: w_r_code = 4'd1;
      6'b100000: w_r_code = 4'd2;
      6'b100010: w_r_code = 4'd6;
      6'b101010: w_r_code = 4'd7;
`ifdef CTRL_MUL_EN
      6'b011000: begin
        w_r_code = 4'd3;
        w_is_mul = 1'b1;
      end
`endif
      default:   w_r_valid = 1'b0;
    endcase
  end

  // Only add, sub and addi trap on signed overflow; mul and the logic ops never do.
  assign w_mul_op    = w_is_r & w_is_mul;
  assign w_ovf_chk   = w_is_addi | (w_is_r & ((w_funct == 6'b100000) | (w_funct == 6'b100010)));
  assign w_exec_code = w_is_r ? w_r_code : (w_is_beq ? 4'd6 : 4'd2);
  assign w_exec_imm  = w_is_lw | w_is_sw | w_is_addi;
  assign w_exec_dst  = w_is_r & w_r_valid;
  assign w_pc_plus4  = r_pc + 8'd4;
  assign w_br_target = r_pc + 8'd4 + {r_ir[5:0], 2'b00};

  // Outputs are registered for the state being entered, so each transition sets them.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_ir          <= '0;
      r_epc         <= '0;
      r_exc_cause   <= 2'b00;
      r_ir_write    <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_epc_write   <= 1'b0;
      r_alu_control <= 4'd2;
      r_alu_src_imm <= 1'b0;
      r_reg_dst     <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_mul_cnt     <= '0;
    end else begin
      r_ir_write    <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_epc_write   <= 1'b0;
      r_alu_control <= 4'd2;
      r_alu_src_imm <= 1'b0;
      r_reg_dst     <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      if (SYS_load) begin
        r_pc       <= SYS_pc_val;
        r_state    <= S_FETCH;
        r_ir_write <= 1'b1;
        r_mul_cnt  <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_FETCH: begin
            r_ir    <= seq_instruction;
            r_state <= S_DECODE;
          end
          S_DECODE: begin
            if (w_is_j) begin
              r_pc       <= {r_ir[5:0], 2'b00};
              r_state    <= S_FETCH;
              r_ir_write <= 1'b1;
            end else if (w_op_valid) begin
              r_state       <= S_EXEC;
              r_alu_control <= w_exec_code;
              r_alu_src_imm <= w_exec_imm;
              r_reg_dst     <= w_exec_dst;
              r_mul_cnt     <= 8'(MUL_LAT);
            end else begin
              r_exc_cause <= 2'b01;
              r_state     <= S_EXC;
              r_epc_write <= 1'b1;
            end
          end
          S_EXEC: begin
            if (w_mul_op && (r_mul_cnt != 8'd0)) begin
              r_mul_cnt     <= r_mul_cnt - 8'd1;
              r_alu_control <= w_exec_code;
              r_alu_src_imm <= w_exec_imm;
              r_reg_dst     <= w_exec_dst;
            end else if (w_is_r && !w_r_valid) begin
              r_exc_cause <= 2'b01;
              r_state     <= S_EXC;
              r_epc_write <= 1'b1;
            end else if (w_is_beq) begin
              r_pc       <= seq_alu_zero ? w_br_target : w_pc_plus4;
              r_state    <= S_FETCH;
              r_ir_write <= 1'b1;
            end else if (w_ovf_chk && seq_alu_ovf) begin
              r_exc_cause <= 2'b10;
              r_state     <= S_EXC;
              r_epc_write <= 1'b1;
            end else if (w_is_lw || w_is_sw) begin
              r_state       <= S_MEM;
              r_mem_read    <= w_is_lw;
              r_mem_write   <= w_is_sw;
              r_alu_src_imm <= 1'b1;
            end else begin
              r_state     <= S_WB;
              r_reg_write <= 1'b1;
              r_reg_dst   <= w_is_r;
            end
          end
          S_MEM: begin
            if (w_is_sw) begin
              r_pc       <= w_pc_plus4;
              r_state    <= S_FETCH;
              r_ir_write <= 1'b1;
            end else begin
              r_state      <= S_WB;
              r_reg_write  <= 1'b1;
              r_mem_to_reg <= 1'b1;
            end
          end
          S_WB: begin
            r_pc       <= w_pc_plus4;
            r_state    <= S_FETCH;
            r_ir_write <= 1'b1;
          end
          S_EXC: begin
            r_epc      <= r_pc;
            r_pc       <= EXC_VECTOR;
            r_state    <= S_FETCH;
            r_ir_write <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // A load abandons the current instruction, so its strobes are masked in that same cycle.
  assign seq_ir_write    = r_ir_write & ~SYS_load;
  assign seq_reg_write   = r_reg_write & ~SYS_load;
  assign seq_mem_read    = r_mem_read & ~SYS_load;
  assign seq_mem_write   = r_mem_write & ~SYS_load;
  assign seq_epc_write   = r_epc_write & ~SYS_load;
  assign seq_pc          = r_pc;
  assign seq_ir          = r_ir;
  assign seq_alu_control = r_alu_control;
  assign seq_alu_src_imm = r_alu_src_imm;
  assign seq_reg_dst     = r_reg_dst;
  assign seq_mem_to_reg  = r_mem_to_reg;
  assign seq_epc         = r_epc;
  assign seq_exc_cause   = r_exc_cause;
  assign seq_state       = r_state;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed scenarios plus random programs checked against
// per-instruction expected traces built from the instruction-set rules.
module tb_mc_sequencer;
  localparam int MUL_LAT = 3;
  localparam logic [7:0] EXC_VECTOR = 8'hF0;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_EXC = 3'd6;
  localparam logic [7:0] B_IRW = 8'h80, B_RW = 8'h40, B_MR = 8'h20, B_MW = 8'h10,
                         B_EW = 8'h08, B_IMM = 8'h04, B_DST = 8'h02, B_M2R = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  pc_val;
  logic [31:0] instr;
  logic        zero;
  logic        ovf;
  logic [7:0]  seq_pc;
  logic [31:0] seq_ir;
  logic        seq_ir_write;
  logic [3:0]  seq_alu_control;
  logic        seq_alu_src_imm;
  logic        seq_reg_dst;
  logic        seq_reg_write;
  logic        seq_mem_read;
  logic        seq_mem_write;
  logic        seq_mem_to_reg;
  logic [7:0]  seq_epc;
  logic        seq_epc_write;
  logic [1:0]  seq_exc_cause;
  logic [2:0]  seq_state;

  logic [31:0] imem [256];
  assign instr = imem[seq_pc];

  mc_sequencer dut (
    .SYS_clk(clk), .SYS_reset(rst), .SYS_load(load), .SYS_pc_val(pc_val),
    .seq_instruction(instr), .seq_alu_zero(zero), .seq_alu_ovf(ovf),
    .seq_pc(seq_pc), .seq_ir(seq_ir), .seq_ir_write(seq_ir_write),
    .seq_alu_control(seq_alu_control), .seq_alu_src_imm(seq_alu_src_imm),
    .seq_reg_dst(seq_reg_dst), .seq_reg_write(seq_reg_write),
    .seq_mem_read(seq_mem_read), .seq_mem_write(seq_mem_write),
    .seq_mem_to_reg(seq_mem_to_reg), .seq_epc(seq_epc), .seq_epc_write(seq_epc_write),
    .seq_exc_cause(seq_exc_cause), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  m_pc;
  logic [7:0]  m_epc;
  logic [1:0]  m_cause;
  logic [14:0] exp_q[$];

  function automatic logic [14:0] observe();
    return {seq_state, seq_alu_control, seq_ir_write, seq_reg_write, seq_mem_read,
            seq_mem_write, seq_epc_write, seq_alu_src_imm, seq_reg_dst, seq_mem_to_reg};
  endfunction

  // Expected per-cycle trace of one instruction from its class and the ALU flags.
  task automatic build_trace(input logic [31:0] ins, input logic [7:0] pc, input logic z,
                             input logic o, output logic [7:0] nxt, output logic exc,
                             output logic [1:0] cause);
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic       r_ok;
    logic       is_mul;
    logic       traps;
    int         n_exec;
    op = ins[31:26];
    fn = ins[5:0];
    exc = 1'b0;
    cause = 2'b00;
    nxt = pc + 8'd4;
    exp_q.push_back({ST_FETCH, 4'd2, B_IRW});
    exp_q.push_back({ST_DECODE, 4'd2, 8'h00});
    if (op == 6'b000010) begin
      nxt = {fn, 2'b00};
    end else if (!(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000})) begin
      exc = 1'b1;
      cause = 2'b01;
    end else if (op == 6'b000100) begin
      exp_q.push_back({ST_EXEC, 4'd6, 8'h00});
      nxt = z ? (pc + 8'd4 + {fn, 2'b00}) : (pc + 8'd4);
    end else begin
      code = 4'd2;
      r_ok = 1'b1;
      is_mul = 1'b0;
      traps = (op == 6'b001000);
      if (op == 6'b000000) begin
        case (fn)
          6'h24: code = 4'd0;
          6'h25: code = 4'd1;
          6'h20: begin code = 4'd2; traps = 1'b1; end
          6'h22: begin code = 4'd6; traps = 1'b1; end
          6'h2A: code = 4'd7;
`ifdef CTRL_MUL_EN
          6'h18: begin code = 4'd3; is_mul = 1'b1; end
`endif
          default: r_ok = 1'b0;
        endcase
      end
      if (!r_ok) begin
        exp_q.push_back({ST_EXEC, 4'd2, 8'h00});
        exc = 1'b1;
        cause = 2'b01;
      end else begin
        n_exec = is_mul ? 1 + MUL_LAT : 1;
        for (int i = 0; i < n_exec; i++)
          exp_q.push_back({ST_EXEC, code, (op == 6'b000000) ? B_DST : B_IMM});
        if (traps && o) begin
          exc = 1'b1;
          cause = 2'b10;
        end else if (op == 6'b100011) begin
          exp_q.push_back({ST_MEM, 4'd2, B_MR | B_IMM});
          exp_q.push_back({ST_WB, 4'd2, B_RW | B_M2R});
        end else if (op == 6'b101011) begin
          exp_q.push_back({ST_MEM, 4'd2, B_MW | B_IMM});
        end else begin
          exp_q.push_back({ST_WB, 4'd2, B_RW | ((op == 6'b000000) ? B_DST : 8'h00)});
        end
      end
    end
    if (exc) begin
      exp_q.push_back({ST_EXC, 4'd2, B_EW});
      nxt = EXC_VECTOR;
    end
  endtask

  // Entered #1 after the edge that put the DUT in FETCH; returns at the same point.
  task automatic run_instr(input string tag, input logic z, input logic o);
    logic [31:0] ins;
    logic [7:0]  start_pc;
    logic [7:0]  nxt;
    logic        exc;
    logic [1:0]  cause;
    logic [14:0] exp_v;
    logic [14:0] obs;
    int          idx;
    ins = imem[m_pc];
    start_pc = m_pc;
    zero = z;
    ovf = o;
    exp_q.delete();
    build_trace(ins, start_pc, z, o, nxt, exc, cause);
    idx = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      @(negedge clk);
      obs = observe();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s trace cyc%0d ins=%h: got %h expected %h", tag, idx, ins, obs, exp_v);
      end
      checks++;
      if (seq_pc !== start_pc) begin
        errors++;
        $display("FAIL %s pc_hold cyc%0d: got %h expected %h", tag, idx, seq_pc, start_pc);
      end
      if (idx > 0) begin
        checks++;
        if (seq_ir !== ins) begin
          errors++;
          $display("FAIL %s ir cyc%0d: got %h expected %h", tag, idx, seq_ir, ins);
        end
      end
      @(posedge clk);
      #1;
      idx++;
    end
    m_pc = nxt;
    if (exc) begin
      m_epc = start_pc;
      m_cause = cause;
    end
    checks++;
    if ({seq_state, seq_pc, seq_epc, seq_exc_cause} !== {ST_FETCH, m_pc, m_epc, m_cause}) begin
      errors++;
      $display("FAIL %s post state/pc/epc/cause: got %0d/%h/%h/%0d expected %0d/%h/%h/%0d",
               tag, seq_state, seq_pc, seq_epc, seq_exc_cause, ST_FETCH, m_pc, m_epc, m_cause);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    load = 1'b1;
    pc_val = v;
    @(posedge clk);
    #1;
    load = 1'b0;
    m_pc = v;
  endtask

  task automatic check_pc(input string tag, input logic [7:0] want);
    checks++;
    if (seq_pc !== want) begin
      errors++;
      $display("FAIL %s pc: got %h expected %h", tag, seq_pc, want);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  x;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 12);
    case (k)
      0: w = {6'h00, w[25:6], 6'h20};
      1: w = {6'h00, w[25:6], 6'h22};
      2: w = {6'h00, w[25:6], 6'h24};
      3: w = {6'h00, w[25:6], 6'h25};
      4: w = {6'h00, w[25:6], 6'h2A};
      5: w = {6'h00, w[25:6], 6'h18};
      6: begin
        do x = 6'($urandom); while (x inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
        w = {6'h00, w[25:6], x};
      end
      7:  w = {6'h23, w[25:0]};
      8:  w = {6'h2B, w[25:0]};
      9:  w = {6'h04, w[25:0]};
      10: w = {6'h08, w[25:0]};
      11: w = {6'h02, w[25:0]};
      default: begin
        do x = 6'($urandom); while (x inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02});
        w = {x, w[25:0]};
      end
    endcase
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({observe(), seq_pc, seq_ir, seq_epc, seq_exc_cause} !==
        {ST_IDLE, 4'd2, 8'h00, 8'h00, 32'h0, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_values: got %h pc=%h ir=%h epc=%h cause=%0d", observe(), seq_pc,
               seq_ir, seq_epc, seq_exc_cause);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({observe(), seq_pc} !== {ST_IDLE, 4'd2, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL idle_hold: got %h pc=%h expected state 0 quiet pc=00", observe(), seq_pc);
    end
    m_pc = 8'h00;
    m_epc = 8'h00;
    m_cause = 2'b00;
  endtask

  task automatic test_directed();
    imem[8'h10] = 32'h00221820;
    do_load(8'h10);
    run_instr("add", 1'b0, 1'b0);
    check_pc("add", 8'h14);
    imem[8'h20] = 32'h8C040008;
    imem[8'h24] = 32'hAC040008;
    do_load(8'h20);
    run_instr("lw", 1'b0, 1'b0);
    run_instr("sw", 1'b0, 1'b0);
    check_pc("sw", 8'h28);
    imem[8'h30] = 32'h10000003;
    do_load(8'h30);
    run_instr("beq_taken", 1'b1, 1'b0);
    check_pc("beq_taken", 8'h40);
    do_load(8'h30);
    run_instr("beq_not", 1'b0, 1'b0);
    check_pc("beq_not", 8'h34);
    imem[8'h44] = 32'hFC000000;
    do_load(8'h44);
    run_instr("undef_op", 1'b0, 1'b0);
    checks++;
    if ({seq_epc, seq_exc_cause, seq_pc} !== {8'h44, 2'b01, 8'hF0}) begin
      errors++;
      $display("FAIL undef_op epc/cause/pc: got %h/%0d/%h expected 44/1/f0", seq_epc,
               seq_exc_cause, seq_pc);
    end
    imem[8'h50] = 32'h20010001;
    do_load(8'h50);
    run_instr("addi_ovf", 1'b0, 1'b1);
    checks++;
    if ({seq_epc, seq_exc_cause, seq_pc} !== {8'h50, 2'b10, 8'hF0}) begin
      errors++;
      $display("FAIL addi_ovf epc/cause/pc: got %h/%0d/%h expected 50/2/f0", seq_epc,
               seq_exc_cause, seq_pc);
    end
    imem[8'h60] = 32'h0000003F;
    do_load(8'h60);
    run_instr("bad_funct", 1'b0, 1'b0);
    imem[8'h70] = 32'h00221818;
    do_load(8'h70);
    run_instr("mul", 1'b0, 1'b1);
    imem[8'hFC] = 32'h0800003F;
    do_load(8'hFC);
    run_instr("jump", 1'b0, 1'b0);
    check_pc("jump", 8'hFC);
    imem[8'hFC] = 32'h20010001;
    run_instr("wrap", 1'b0, 1'b0);
    check_pc("wrap", 8'h00);
  endtask

  task automatic test_load_abort();
    imem[8'h80] = 32'h00221820;
    imem[8'h90] = 32'hAC040008;
    do_load(8'h80);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    load = 1'b1;
    pc_val = 8'h90;
    #1;
    checks++;
    if ({seq_state, seq_ir_write, seq_reg_write, seq_mem_read, seq_mem_write, seq_epc_write} !==
        {ST_WB, 5'b00000}) begin
      errors++;
      $display("FAIL load_abort strobes: got state %0d strobes %b expected 5 00000", seq_state,
               {seq_ir_write, seq_reg_write, seq_mem_read, seq_mem_write, seq_epc_write});
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    m_pc = 8'h90;
    run_instr("after_abort", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) imem[i] = rand_instr();
    do_load(8'($urandom));
    for (int n = 0; n < 300; n++)
      run_instr("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
  endtask

  task automatic test_async_reset();
    imem[8'hA0] = 32'h00221820;
    do_load(8'hA0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (seq_state !== ST_EXEC) begin
      errors++;
      $display("FAIL async_reset pre: got state %0d expected %0d", seq_state, ST_EXEC);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({observe(), seq_pc, seq_ir, seq_epc, seq_exc_cause} !==
        {ST_IDLE, 4'd2, 8'h00, 8'h00, 32'h0, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL async_reset: got %h pc=%h expected state 0 quiet pc=00", observe(), seq_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    m_pc = 8'h00;
    m_epc = 8'h00;
    m_cause = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    pc_val = 8'h00;
    zero = 1'b0;
    ovf = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    test_reset();
    test_directed();
    test_load_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multicycle control FSM for the 8-bit-PC MIPS datapath. It owns the PC, latches each instruction from IMEM and decodes it. It steps REG/ALU/DMEM through FETCH→DECODE→EXEC→MEM→WB, emitting per-cycle strobes, the 4-bit ALU_control code and an exception/EPC capture path. It sits inside `system` between IMEM and the datapath muxes.

Parameters:
RESET_PC, 8'h00, PC value after reset
EXC_VECTOR, 8'hF0, PC loaded on exception entry
MUL_LAT, 3, extra EXEC cycles held for multiply (only with CTRL_MUL_EN)

Ports:
SYS_clk  in  1  clock, all state updates on rising edge
SYS_reset  in  1  asynchronous, active-high reset
SYS_load  in  1  load PC from SYS_pc_val and start/restart execution
SYS_pc_val  in  8  PC load value
seq_instruction  in  32  IMEM_instruction at seq_pc
seq_alu_zero  in  1  ALU result == 0, combinational, valid in EXEC
seq_alu_ovf  in  1  signed overflow of current ALU op, valid in EXEC
seq_pc  out  8  current PC, drives IMEM_PC
seq_ir  out  32  latched instruction
seq_ir_write  out  1  instruction latch strobe
seq_alu_control  out  4  ALU code (0 and, 1 or, 2 add, 3 mul, 6 sub, 7 slt)
seq_alu_src_imm  out  1  ALU operand 2 = sign-extended imm
seq_reg_dst  out  1  1: write rd, 0: write rt
seq_reg_write  out  1  register file write strobe
seq_mem_read  out  1  DMEM read enable
seq_mem_write  out  1  DMEM write strobe
seq_mem_to_reg  out  1  writeback source = DMEM
seq_epc  out  8  PC of last faulting instruction
seq_epc_write  out  1  one-cycle pulse on exception entry
seq_exc_cause  out  2  00 none, 01 undefined op/funct, 10 overflow
seq_state  out  3  FSM state encoding

Behaviour:
- Reset (async, SYS_reset=1):
  - state IDLE(0); seq_pc=RESET_PC; seq_ir=0; seq_epc=0; seq_exc_cause=00.
  - All strobes 0; seq_alu_control=4'b0010; seq_alu_src_imm, seq_reg_dst, seq_mem_to_reg = 0.
- Priority: reset > SYS_load > everything else.
  - SYS_load=1 in any state: seq_pc<=SYS_pc_val; next state FETCH.
  - All strobes 0 in that cycle; any in-flight instruction is abandoned with no writes.
- States: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, EXC 6.
- IDLE: all outputs quiescent; leaves only on SYS_load.
- FETCH: seq_ir_write=1; seq_ir<=seq_instruction. →DECODE.
- DECODE, on seq_ir[31:26]:
  - 000000 R, 100011 lw, 101011 sw, 000100 beq, 001000 addi: →EXEC.
  - 000010 j: seq_pc<={seq_ir[5:0],2'b00}; →FETCH.
  - Any other opcode: cause 01, →EXC.
- EXEC: seq_alu_control is driven from seq_ir.
  - R-type funct: 100100→0, 100101→1, 100000→2, 100010→6, 101010→7, seq_reg_dst=1. Other funct: cause 01, →EXC.
  - lw/sw/addi: code 2, seq_alu_src_imm=1.
  - beq: code 6.
    - seq_alu_zero=1: seq_pc<=seq_pc+4+{seq_ir[5:0],2'b00}.
    - Otherwise: seq_pc<=seq_pc+4.
    - Either way →FETCH.
  - add/sub/addi with seq_alu_ovf=1: cause 10, →EXC, no writeback.
  - Otherwise: R/addi →WB; lw/sw →MEM.
- MEM:
  - sw: seq_mem_write=1, seq_alu_src_imm=1, seq_pc<=seq_pc+4, →FETCH.
  - lw: seq_mem_read=1, seq_alu_src_imm=1, →WB.
- WB:
  - seq_reg_write=1.
  - seq_mem_to_reg=1 for lw; seq_reg_dst=1 for R-type.
  - seq_pc<=seq_pc+4. →FETCH.
- EXC:
  - seq_epc<=seq_pc (PC is unchanged since fetch); seq_epc_write=1.
  - seq_pc<=EXC_VECTOR. →FETCH.
  - seq_exc_cause holds until the next exception or reset.
- Arithmetic: all PC arithmetic is 8-bit modulo 256 (8'hFC+4=8'h00). The branch offset is truncated to 8 bits.
- Strobes are asserted only in their named state; each is 1 cycle wide. A non-EXEC state drives code 2.
- Latency:
  - R/addi 4 cycles; lw 5; sw 4; beq 3; j 2.
  - Exception 3 cycles after its detecting state, i.e. fetch to vector.

Optional Feature:
CTRL_MUL_EN
- Defined:
  - R funct 011000 → code 3, reg_dst=1.
  - EXEC is held for 1+MUL_LAT cycles (internal down-counter), then →WB.
  - seq_alu_ovf is ignored for mul.
  - SYS_load mid-hold aborts the hold.
- Undefined: funct 011000 is undefined → cause 01 exception.

Test Plan:
- Reset then SYS_load with SYS_pc_val=8'h10, IMEM[0x10]=add $3,$1,$2 → FETCH→DECODE→EXEC (code 2)→WB; reg_write pulse with reg_dst=1; seq_pc=8'h14.
- lw $4,8($0) at 0x20 → mem_read only in MEM cycle; WB with mem_to_reg=1; 5 cycles total; sw at 0x24 → mem_write 1 cycle, no reg_write, pc=8'h28.
- beq at 0x30, imm=3:
  - alu_zero=1 → pc=8'h40.
  - alu_zero=0 → pc=8'h34.
  - Neither case asserts reg_write or mem_write.
- Opcode 6'b111111 at 0x44 → epc=8'h44, epc_write pulse, cause=01, pc=8'hF0.
- addi with alu_ovf=1 in EXEC → cause=10, no reg_write, pc=8'hF0.
- j to 6'h3F at 0xFC → pc=8'hFC. Separately: assert SYS_reset mid-EXEC → state=0 and all strobes 0 immediately (asynchronous, not waiting for a clock edge).
